// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// constants, datapath mux/ALU codes and the control-strobe bundle.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_JR    = 6'h08;
    localparam logic [OP_W-1:0] FN_ADDU  = 6'h21;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'h23;

    localparam logic [SEL_W-1:0] NPC_SEQ  = 2'd0;
    localparam logic [SEL_W-1:0] NPC_BR   = 2'd1;
    localparam logic [SEL_W-1:0] NPC_JUMP = 2'd2;
    localparam logic [SEL_W-1:0] NPC_REG  = 2'd3;

    localparam logic [SEL_W-1:0] RD_RT = 2'd0;
    localparam logic [SEL_W-1:0] RD_RD = 2'd1;
    localparam logic [SEL_W-1:0] RD_RA = 2'd2;

    localparam logic [SEL_W-1:0] WD_ALU  = 2'd0;
    localparam logic [SEL_W-1:0] WD_MEM  = 2'd1;
    localparam logic [SEL_W-1:0] WD_LINK = 2'd2;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_LUI = 3'd3;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ,
        C_J, C_JAL, C_JR, C_UNDEF
    } iclass_t;

    typedef struct packed {
        logic               pc_we;
        logic               ir_we;
        logic [SEL_W-1:0]   npc_sel;
        logic [SEL_W-1:0]   regdst;
        logic [SEL_W-1:0]   memtoreg;
        logic               regwrite;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               ext_op;
        logic               memwrite;
        logic               memread;
    } ctrl_t;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               ext_op;
    } alu_ctrl_t;

    // ALU operation, operand-B source and immediate extension for each class
    function automatic alu_ctrl_t alu_ctrl(input iclass_t c);
        alu_ctrl_t a;
        a = '0;
        case (c)
            C_ADDU:      a.aluop = ALU_ADD;
            C_SUBU:      a.aluop = ALU_SUB;
            C_BEQ:       a.aluop = ALU_SUB;
            C_ORI: begin
                a.aluop  = ALU_OR;
                a.alusrc = 1'b1;
            end
            C_LUI: begin
                a.aluop  = ALU_LUI;
                a.alusrc = 1'b1;
            end
            C_LW, C_SW: begin
                a.aluop  = ALU_ADD;
                a.alusrc = 1'b1;
                a.ext_op = 1'b1;
            end
            default:     a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Instruction classifier: maps IR op/funct fields onto the control FSM's classes.
module mc_decode
    import mips_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] funct,
    output iclass_t         iclass_c
);

    always_comb begin
        iclass_c = C_UNDEF;
        case (op)
            OP_RTYPE: begin
                // sll-encoded nop and other R-type functs stay C_UNDEF
                case (funct)
                    FN_ADDU: iclass_c = C_ADDU;
                    FN_SUBU: iclass_c = C_SUBU;
                    FN_JR:   iclass_c = C_JR;
                    default: iclass_c = C_UNDEF;
                endcase
            end
            OP_ORI:  iclass_c = C_ORI;
            OP_LUI:  iclass_c = C_LUI;
            OP_LW:   iclass_c = C_LW;
            OP_SW:   iclass_c = C_SW;
            OP_BEQ:  iclass_c = C_BEQ;
            OP_J:    iclass_c = C_J;
            OP_JAL:  iclass_c = C_JAL;
            default: iclass_c = C_UNDEF;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving the
// datapath strobes, plus a retired-instruction counter.
module mc_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic [OP_W-1:0]      funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_we,
    output logic                 ir_we,
    output logic [SEL_W-1:0]     npc_sel,
    output logic [SEL_W-1:0]     regdst,
    output logic [SEL_W-1:0]     memtoreg,
    output logic                 regwrite,
    output logic                 alusrc,
    output logic [ALUOP_W-1:0]   aluop,
    output logic                 ext_op,
    output logic                 memwrite,
    output logic                 memread,
    output logic [STATE_W-1:0]   state,
    output logic [CNT_W-1:0]     retire_cnt
);

    state_t       state_q;
    state_t       state_d;
    iclass_t      iclass;
    ctrl_t        ctrl;
    alu_ctrl_t    alu;
    logic         retire;
    logic [CNT_W-1:0] retire_q;

    mc_decode u_decode (
        .op       (op),
        .funct    (funct),
        .iclass_c (iclass)
    );

    assign alu = alu_ctrl(iclass);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Counts every return to FETCH that completes an instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
        end else if (retire) begin
            retire_q <= retire_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = S_FETCH;
        ctrl    = '0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_we   = 1'b1;
                ctrl.pc_we   = 1'b1;
                ctrl.npc_sel = NPC_SEQ;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                case (iclass)
                    C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ: begin
                        state_d = S_EXEC;
                    end
                    C_J: begin
                        ctrl.pc_we   = 1'b1;
                        ctrl.npc_sel = NPC_JUMP;
                        retire       = 1'b1;
                    end
                    C_JR: begin
                        ctrl.pc_we   = 1'b1;
                        ctrl.npc_sel = NPC_REG;
                        retire       = 1'b1;
                    end
                    C_JAL: begin
                        ctrl.pc_we    = 1'b1;
                        ctrl.npc_sel  = NPC_JUMP;
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = RD_RA;
                        ctrl.memtoreg = WD_LINK;
                        retire        = 1'b1;
                    end
                    default: retire = 1'b1;
                endcase
            end
            S_EXEC: begin
                ctrl.aluop  = alu.aluop;
                ctrl.alusrc = alu.alusrc;
                ctrl.ext_op = alu.ext_op;
                case (iclass)
                    C_BEQ: begin
                        ctrl.pc_we   = zero;
                        ctrl.npc_sel = NPC_BR;
                        retire       = 1'b1;
                    end
                    C_LW, C_SW:                  state_d = S_MEM;
                    C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
                    default:                     retire = 1'b1;
                endcase
            end
            S_MEM: begin
                ctrl.memread  = (iclass == C_LW);
                ctrl.memwrite = (iclass == C_SW);
                if (!mem_ready) begin
                    state_d = S_MEM;
                end else if (iclass == C_LW) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_WB: begin
                ctrl.aluop  = alu.aluop;
                ctrl.alusrc = alu.alusrc;
                ctrl.ext_op = alu.ext_op;
                case (iclass)
                    C_ADDU, C_SUBU: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = RD_RD;
                        ctrl.memtoreg = WD_ALU;
                    end
                    C_ORI, C_LUI: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = RD_RT;
                        ctrl.memtoreg = WD_ALU;
                    end
                    C_LW: begin
                        ctrl.regwrite = 1'b1;
                        ctrl.regdst   = RD_RT;
                        ctrl.memtoreg = WD_MEM;
                    end
                    default: ctrl.regwrite = 1'b0;
                endcase
                retire = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset must silence the strobes at once, even before any clock edge
        if (reset) begin
            ctrl = '0;
        end
    end

    assign pc_we      = ctrl.pc_we;
    assign ir_we      = ctrl.ir_we;
    assign npc_sel    = ctrl.npc_sel;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign regwrite   = ctrl.regwrite;
    assign alusrc     = ctrl.alusrc;
    assign aluop      = ctrl.aluop;
    assign ext_op     = ctrl.ext_op;
    assign memwrite   = ctrl.memwrite;
    assign memread    = ctrl.memread;
    assign state      = state_q;
    assign retire_cnt = retire_q;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port op, input, 6, IR[31:26], valid from the cycle after FETCH.
REQ-004 SHALL have port funct, input, 6, IR[5:0].
REQ-005 SHALL have port zero, input, 1, ALU equality flag for beq.
REQ-006 SHALL have port mem_ready, input, 1, data memory done; sampled in MEM.
REQ-007 SHALL have port pc_we, output, 1, PC register write strobe.
REQ-008 SHALL have port ir_we, output, 1, IR write strobe.
REQ-009 SHALL have port npc_sel, output, 2, next-PC source: 0=PC+4, 1=branch, 2=j/jal target, 3=GPR[rs].
REQ-010 SHALL have port regdst, output, 2, write-address select: 0=rt, 1=rd, 2=$31.
REQ-011 SHALL have port memtoreg, output, 2, write-data select: 0=ALU, 1=memory, 2=link (PC+4).
REQ-012 SHALL have port regwrite, output, 1, GPR write strobe.
REQ-013 SHALL have port alusrc, output, 1, 0=GPR[rt], 1=extended immediate.
REQ-014 SHALL have port aluop, output, 3, 0=add, 1=sub, 2=or, 3=lui-shift.
REQ-015 SHALL have port ext_op, output, 1, 0=zero-extend, 1=sign-extend.
REQ-016 SHALL have ports memwrite/memread, output, 1 each, data memory strobes.
REQ-017 SHALL have port state, output, 3, current FSM state, debug only.
REQ-018 SHALL have port retire_cnt, output, 32, retired-instruction count.

Function
REQ-019 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH next cycle with all strobes 0.
REQ-020 FETCH SHALL assert ir_we=1, pc_we=1, npc_sel=0 for exactly one cycle, then go to DECODE.
REQ-021 DECODE: addu/subu/ori/lui/lw/sw/beq -> EXEC; j -> FETCH with pc_we=1, npc_sel=2; jr -> FETCH with pc_we=1, npc_sel=3.
REQ-022 DECODE for jal SHALL in one cycle assert pc_we=1, npc_sel=2, regwrite=1, regdst=2, memtoreg=2, then go to FETCH.
REQ-023 Unsupported op/funct (incl. nop) SHALL go DECODE -> FETCH with no writes; counted as retired.
REQ-024 EXEC: beq asserts aluop=1, pc_we=zero, npc_sel=1, then -> FETCH; lw/sw -> MEM; addu/subu/ori/lui -> WB.
REQ-025 EXEC/WB decode: addu aluop=0; subu aluop=1; ori aluop=2, alusrc=1, ext_op=0; lui aluop=3, alusrc=1; lw/sw aluop=0, alusrc=1, ext_op=1.
REQ-026 MEM: memwrite=1 (sw) or memread=1 (lw) held while mem_ready=0; when mem_ready=1, sw -> FETCH, lw -> WB.
REQ-027 WB SHALL assert regwrite=1 for one cycle: R-type regdst=1, memtoreg=0; ori/lui regdst=0, memtoreg=0; lw regdst=0, memtoreg=1; then -> FETCH.
REQ-028 retire_cnt SHALL increment by 1 on every transition into FETCH from DECODE/EXEC/MEM/WB; wraps 0xFFFFFFFF -> 0.
REQ-029 Outputs other than state/retire_cnt SHALL be combinational from state, op, funct, zero, mem_ready; unlisted outputs default to 0.
REQ-030 CPI SHALL be: j/jr/jal/nop 2, beq 3, R/ori/lui 4, sw 4, lw 5, each plus one per mem_ready=0 cycle in MEM.

Reset
REQ-031 reset=1 SHALL immediately force state=FETCH, retire_cnt=0, and all strobes (pc_we, ir_we, regwrite, memwrite, memread) to 0, regardless of clk.
REQ-032 Reset mid-instruction (incl. MEM stall) SHALL abandon the instruction uncounted; first edge after release performs FETCH.

Structure
REQ-033 State codes, opcode/funct constants, regdst/memtoreg/npc_sel/aluop codes SHALL live in shared package mips_ctrl_pkg.
REQ-034 Instruction classification (op/funct -> class) SHALL be sub-module mc_decode; FSM and counter stay in mc_ctrl.

Verification
REQ-035 Reset release, addu: states 0,1,2,4,0; WB has regwrite=1, regdst=1; retire_cnt=1.
REQ-036 lw with mem_ready low 2 cycles: MEM lasts 3 cycles with memread=1; WB regdst=0, memtoreg=1; total 7 cycles.
REQ-037 beq zero=1 -> EXEC pc_we=1, npc_sel=1; zero=0 -> pc_we=0; both 3 cycles.
REQ-038 jal: DECODE shows regdst=2, memtoreg=2, regwrite=1, pc_we=1, npc_sel=2; next state FETCH.
REQ-039 reset asserted in MEM of sw: memwrite drops to 0 without clk edge; retire_cnt unchanged at 0.
REQ-040 op=0x3F undefined: 2-cycle retire, no write strobes; retire_cnt preload 0xFFFFFFFF wraps to 0.
